// File: rtl/led_ctrl.sv
// Memory-mapped LED controller: static, blink and chase modes with a shared prescaler.
// Optional brightness PWM on offset 0x10 when LED_PWM_EN is defined.
module led_ctrl #(
   parameter int unsigned PERIOD_W = 24
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] addr,
   input  logic        we,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic [15:0] led
);

   localparam int unsigned LED_W     = 16;
   localparam int unsigned OFF_W     = 3;
   localparam logic [OFF_W-1:0] OFF_VALUE  = OFF_W'(0);
   localparam logic [OFF_W-1:0] OFF_MODE   = OFF_W'(1);
   localparam logic [OFF_W-1:0] OFF_PERIOD = OFF_W'(2);
   localparam logic [OFF_W-1:0] OFF_STATUS = OFF_W'(3);
   localparam logic [OFF_W-1:0] OFF_BRIGHT = OFF_W'(4);
   localparam logic [1:0] MODE_CHASE_L = 2'd2;

   typedef enum logic [1:0] {
      ST_STATIC    = 2'd0,
      ST_BLINK_ON  = 2'd1,
      ST_BLINK_OFF = 2'd2,
      ST_CHASE     = 2'd3
   } state_t;

   state_t              state;
   state_t              state_n;
   logic [LED_W-1:0]    value;
   logic [1:0]          mode;
   logic [PERIOD_W-1:0] period;
   logic [PERIOD_W-1:0] cnt;
   logic [PERIOD_W-1:0] cnt_max;
   logic [LED_W-1:0]    pat;
   logic [LED_W-1:0]    pat_n;
   logic [OFF_W-1:0]    word;
   logic                wr_value;
   logic                wr_mode;
   logic                wr_period;
   logic                wr_any;
   logic                tick;
   logic                tick_eff;
   logic                blink_on;
   logic                chase_left;
   logic                unused_bits;

   assign word       = addr[4:2];
   assign wr_value   = we && (word == OFF_VALUE);
   assign wr_mode    = we && (word == OFF_MODE);
   assign wr_period  = we && (word == OFF_PERIOD);
   assign wr_any     = wr_value || wr_mode || wr_period;
   assign blink_on   = (state == ST_BLINK_ON);
   assign chase_left = (mode == MODE_CHASE_L);
   assign unused_bits = ^{addr[31:5], addr[1:0], wdata};

   // PERIOD of zero behaves as one: tick every cycle.
   assign cnt_max  = (period == '0) ? '0 : period - PERIOD_W'(1);
   assign tick     = (cnt == cnt_max);
   assign tick_eff = tick && !wr_any;

   // Control registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         value  <= '0;
         mode   <= '0;
         period <= '0;
      end else begin
         if (wr_value)  value  <= wdata[LED_W-1:0];
         if (wr_mode)   mode   <= wdata[1:0];
         if (wr_period) period <= wdata[PERIOD_W-1:0];
      end
   end

   // Prescaler; any control write restarts the period
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
      end else if (wr_any || tick) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + PERIOD_W'(1);
      end
   end

   // FSM state and pattern/shift register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= ST_STATIC;
         pat   <= '0;
      end else begin
         state <= state_n;
         pat   <= pat_n;
      end
   end

   // Writes take priority over a coincident tick
   always_comb begin
      state_n = state;
      pat_n   = pat;
      if (wr_mode) begin
         case (wdata[1:0])
            2'd0:    state_n = ST_STATIC;
            2'd1:    state_n = ST_BLINK_ON;
            default: state_n = ST_CHASE;
         endcase
         pat_n = value;
      end else if (wr_value) begin
         if (state != ST_BLINK_OFF) pat_n = wdata[LED_W-1:0];
      end else if (tick_eff) begin
         case (state)
            ST_BLINK_ON: begin
               state_n = ST_BLINK_OFF;
               pat_n   = '0;
            end
            ST_BLINK_OFF: begin
               state_n = ST_BLINK_ON;
               pat_n   = value;
            end
            ST_CHASE: begin
               if (chase_left) pat_n = {pat[LED_W-2:0], pat[LED_W-1]};
               else            pat_n = {pat[0], pat[LED_W-1:1]};
            end
            default: ;
         endcase
      end
   end

`ifdef LED_PWM_EN
   logic [7:0]       bright;
   logic [7:0]       pwm_cnt;
   logic             pwm_on;
   logic [LED_W-1:0] led_q;
   logic             wr_bright;

   assign wr_bright = we && (word == OFF_BRIGHT);
   assign pwm_on    = (bright == 8'hFF) || (pwm_cnt < bright);

   // Brightness register, free-running PWM counter and gated output
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bright  <= 8'hFF;
         pwm_cnt <= '0;
         led_q   <= '0;
      end else begin
         if (wr_bright) bright <= wdata[7:0];
         pwm_cnt <= pwm_cnt + 8'd1;
         led_q   <= pwm_on ? pat_n : '0;
      end
   end

   assign led = led_q;
`else
   assign led = pat;
`endif

   // Combinational read mux, no side effects
   always_comb begin
      rdata = '0;
      case (word)
         OFF_VALUE:  rdata = {16'h0000, value};
         OFF_MODE:   rdata = {30'h0, mode};
         OFF_PERIOD: rdata = 32'(period);
         OFF_STATUS: rdata = {15'h0, blink_on, pat};
`ifdef LED_PWM_EN
         OFF_BRIGHT: rdata = {24'h0, bright};
`endif
         default:    rdata = '0;
      endcase
   end

endmodule

// File: tb/tb_led_ctrl.sv
// Directed bench for led_ctrl with a tick-counting reference model checked every cycle.
module tb_led_ctrl;

   localparam int unsigned PW = 24;

   logic        clk;
   logic        rst;
   logic [31:0] addr;
   logic        we;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic [15:0] led;

   int total = 0;
   int bad   = 0;
   logic [31:0] rd_a;

   led_ctrl #(.PERIOD_W(PW)) dut (
      .clk(clk), .rst(rst), .addr(addr), .we(we),
      .wdata(wdata), .rdata(rdata), .led(led)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Model: pattern = f(mode, loaded value, number of ticks since load)
   logic [15:0] m_value;
   logic [15:0] m_base;
   logic [1:0]  m_mode;
   logic [31:0] m_period;
   int          m_k;
   int          m_n;
   int          m_p;
   logic [15:0] exp_led;
   logic [7:0]  m_bright;
   int          m_pwm;
   logic        m_on;

   function automatic logic [15:0] rot(input logic [15:0] b, input int r, input bit left);
      logic [31:0] d;
      d = {b, b};
      if (left) begin
         d = d << r;
         return d[31:16];
      end
      d = d >> r;
      return d[15:0];
   endfunction

   function automatic logic [15:0] pat_now();
      case (m_mode)
         2'd0:    return m_value;
         2'd1:    return (m_n % 2 == 0) ? m_value : 16'h0000;
         2'd2:    return rot(m_base, m_n % 16, 1'b1);
         default: return rot(m_base, m_n % 16, 1'b0);
      endcase
   endfunction

   function automatic logic [31:0] exp_rd(input logic [31:0] a);
      logic blink;
      blink = (m_mode == 2'd1) && (m_n % 2 == 0);
      case (a[4:2])
         3'd0: return {16'h0, m_value};
         3'd1: return {30'h0, m_mode};
         3'd2: return m_period;
         3'd3: return {15'h0, blink, pat_now()};
`ifdef LED_PWM_EN
         3'd4: return {24'h0, m_bright};
`endif
         default: return 32'h0;
      endcase
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_value = '0; m_base = '0; m_mode = '0; m_period = '0;
         m_k = 0; m_n = 0; exp_led = '0; m_bright = 8'hFF; m_pwm = 0;
      end else begin
         m_on = (m_bright == 8'hFF) || (m_pwm < int'(m_bright));
         m_pwm = (m_pwm + 1) % 256;
         if (we && addr[4:2] == 3'd0) begin
            m_value = wdata[15:0];
            if (m_mode[1]) begin
               m_base = wdata[15:0];
               m_n = 0;
            end
            m_k = 0;
         end else if (we && addr[4:2] == 3'd1) begin
            m_mode = wdata[1:0];
            m_base = m_value;
            m_n = 0;
            m_k = 0;
         end else if (we && addr[4:2] == 3'd2) begin
            m_period = {8'h0, wdata[PW-1:0]};
            m_k = 0;
         end else begin
            m_p = (m_period == 0) ? 1 : int'(m_period);
            m_k++;
            if (m_k >= m_p) begin
               m_k = 0;
               m_n++;
            end
         end
`ifdef LED_PWM_EN
         if (we && addr[4:2] == 3'd4) m_bright = wdata[7:0];
         exp_led = m_on ? pat_now() : 16'h0000;
`else
         exp_led = pat_now();
`endif
      end
   end

   // Every-cycle comparison against the model
   always @(negedge clk) begin
      total++;
      if (led !== exp_led) begin
         bad++;
         $display("FAIL cyc_led t=%0t got=%h want=%h", $time, led, exp_led);
      end
      total++;
      if (rdata !== exp_rd(addr)) begin
         bad++;
         $display("FAIL cyc_rdata t=%0t addr=%h got=%h want=%h", $time, addr, rdata, exp_rd(addr));
      end
   end

   task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got=%h want=%h", nm, act, exp);
      end
   endtask

   task automatic chk_led(input logic [15:0] exp, input string nm);
      @(negedge clk);
      cmp(nm, {16'h0, led}, {16'h0, exp});
      @(posedge clk); #2;
   endtask

   task automatic chk_rd(input logic [31:0] a, input logic [31:0] exp, input string nm);
      addr = a;
      @(negedge clk);
      cmp(nm, rdata, exp);
      @(posedge clk); #2;
      addr = rd_a;
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d);
      addr = a; wdata = d; we = 1'b1;
      @(posedge clk); #2;
      we = 1'b0; addr = rd_a;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk); #2;
      end
   endtask

   typedef struct packed {
      logic [31:0] a;
      logic [31:0] d;
      logic [7:0]  gap;
      logic [31:0] ra;
   } step_t;

   step_t tbl [14] = '{
      '{32'h08, 32'd2,      8'd1, 32'h0C},
      '{32'h00, 32'h1234,   8'd2, 32'h0C},
      '{32'h04, 32'd1,      8'd5, 32'h0C},
      '{32'h08, 32'd3,      8'd7, 32'h0C},
      '{32'h00, 32'hBEEF,   8'd6, 32'h00},
      '{32'h04, 32'd3,      8'd5, 32'h0C},
      '{32'h00, 32'h0000,   8'd4, 32'h0C},
      '{32'h00, 32'h0F00,   8'd4, 32'h08},
      '{32'h0C, 32'hFFFF,   8'd3, 32'h0C},
      '{32'h14, 32'hAAAA,   8'd2, 32'h14},
      '{32'h04, 32'd2,      8'd5, 32'h04},
      '{32'h08, 32'd0,      8'd3, 32'h0C},
      '{32'h04, 32'd0,      8'd2, 32'h00},
      '{32'h00, 32'h0F00,   8'd2, 32'h0C}
   };

   int pwm_hits;

   initial begin
      rst = 1'b1; we = 1'b0; addr = '0; wdata = '0; rd_a = '0;
      repeat (2) @(posedge clk);
      #2 rst = 1'b0;

      // Reset state
      chk_led(16'h0000, "reset_led");
      chk_rd(32'h00, 32'h0, "reset_value");
      chk_rd(32'h04, 32'h0, "reset_mode");
      chk_rd(32'h08, 32'h0, "reset_period");
      chk_rd(32'h0C, 32'h0, "reset_status");
`ifdef LED_PWM_EN
      chk_rd(32'h10, 32'hFF, "reset_bright");
`else
      chk_rd(32'h10, 32'h0, "reset_bright_absent");
`endif

      // Static write
      wr(32'h00, 32'hA5A5);
      chk_led(16'hA5A5, "static_led");
      chk_rd(32'h0C, 32'h0000A5A5, "static_status");

      // Blink, period 4, starting ON
      rd_a = 32'h0C;
      wr(32'h00, 32'h00FF);
      wr(32'h08, 32'd4);
      wr(32'h04, 32'd1);
      for (int i = 0; i < 12; i++)
         chk_led(((i / 4) % 2 == 0) ? 16'h00FF : 16'h0000, $sformatf("blink_%0d", i));

      // Chase left/right with tick every cycle
      wr(32'h00, 32'h8001);
      wr(32'h08, 32'd0);
      wr(32'h04, 32'd2);
      chk_led(16'h8001, "chase_l_0");
      chk_led(16'h0003, "chase_l_1");
      chk_led(16'h0006, "chase_l_2");
      wr(32'h04, 32'd3);
      chk_led(16'h8001, "chase_r_reload");
      chk_led(16'hC000, "chase_r_1");

      // VALUE write landing on a tick: load without rotation
      wr(32'h08, 32'd3);
      wr(32'h00, 32'h0001);
      wr(32'h04, 32'd2);
      chk_led(16'h0001, "tickw_0");
      chk_led(16'h0001, "tickw_1");
      chk_led(16'h0001, "tickw_2");
      chk_led(16'h0002, "tickw_3");
      chk_led(16'h0002, "tickw_4");
      wr(32'h00, 32'h0010);
      chk_led(16'h0010, "tickw_load");
      chk_led(16'h0010, "tickw_hold1");
      chk_led(16'h0010, "tickw_hold2");
      chk_led(16'h0020, "tickw_rot");

      // Mixed sequence checked by the model
      foreach (tbl[i]) begin
         rd_a = tbl[i].ra;
         wr(tbl[i].a, tbl[i].d);
         idle(int'(tbl[i].gap));
      end

      // Unmapped and read-only offsets
      rd_a = 32'h00;
      chk_led(16'h0F00, "after_table");
      wr(32'h0C, 32'hFFFF);
      wr(32'h1C, 32'h1234);
      chk_led(16'h0F00, "ignored_writes");
      chk_rd(32'h14, 32'h0, "unmapped_rd");
      chk_rd(32'h20, 32'h0F00, "alias_rd");
      wr(32'h10, 32'h55);
`ifdef LED_PWM_EN
      chk_rd(32'h10, 32'h55, "bright_rd");
`else
      chk_rd(32'h10, 32'h0, "bright_absent_rd");
`endif

      // Asynchronous reset mid-blink
      rd_a = 32'h0C;
      wr(32'h00, 32'hFFFF);
      wr(32'h08, 32'd8);
      wr(32'h04, 32'd1);
      chk_led(16'hFFFF, "pre_rst_on");
      #1 rst = 1'b1;
      #1 cmp("async_rst_led", {16'h0, led}, 32'h0);
      cmp("async_rst_status", rdata, 32'h0);
      #1 rst = 1'b0;
      @(posedge clk); #2;
      idle(20);
      chk_led(16'h0000, "post_rst_led");
      chk_rd(32'h04, 32'h0, "post_rst_mode");
      chk_rd(32'h0C, 32'h0, "post_rst_status");

`ifdef LED_PWM_EN
      // Brightness duty cycle
      wr(32'h10, 32'h40);
      wr(32'h00, 32'hFFFF);
      pwm_hits = 0;
      repeat (256) begin
         @(negedge clk);
         if (led == 16'hFFFF) pwm_hits++;
         @(posedge clk); #2;
      end
      cmp("pwm_40", 32'(pwm_hits), 32'd64);
      wr(32'h10, 32'hFF);
      idle(1);
      pwm_hits = 0;
      repeat (256) begin
         @(negedge clk);
         if (led == 16'hFFFF) pwm_hits++;
         @(posedge clk); #2;
      end
      cmp("pwm_ff", 32'(pwm_hits), 32'd256);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
